// File: rtl/clock_mode_ctrl.sv
// Front-panel controller for the digital clock.
// Debounces the five push buttons, sequences RUN / SET_TIME / SET_ALARM,
// drives the timekeeper's set controls and owns the alarm, snooze and ring logic.
module clock_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int RING_SECONDS    = 60,
  parameter int SNOOZE_MINUTES  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       left,
  input  logic       right,
  input  logic       up,
  input  logic       down,
  input  logic       one_hz_tick,
  input  logic [5:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  output logic       set_mod,
  output logic       alarm_edit,
  output logic [2:0] pos,
  output logic       inc,
  output logic       dec,
  output logic [5:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic       alarm_en,
  output logic       ringing
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RCW = $clog2(RING_SECONDS + 1);

  localparam logic [DBW-1:0] CNT_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DBW-1:0] CNT_ONE  = DBW'(1);
  localparam logic [RCW-1:0] RING_LOAD = RCW'(RING_SECONDS);
  localparam logic [RCW-1:0] RING_ONE  = RCW'(1);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_SET_TIME  = 2'd1;
  localparam logic [1:0] ST_SET_ALARM = 2'd2;

  localparam logic [2:0] POS_HOURS   = 3'd0;
  localparam logic [2:0] POS_MINUTES = 3'd1;
  localparam logic [2:0] POS_SECONDS = 3'd2;
  localparam logic [2:0] POS_NONE    = 3'd7;

  // Button bit order: 0 mode, 1 left, 2 right, 3 up, 4 down
  logic [4:0]     btnRaw;
  logic [4:0]     sync1_q;
  logic [4:0]     sync2_q;
  logic [4:0]     stable_q;
  logic [4:0]     stablePrev_q;
  logic [DBW-1:0] cnt_q [5];
  logic [4:0]     press;

  assign btnRaw = {down, up, right, left, mode_btn};
  assign press  = stable_q & ~stablePrev_q;

  // Synchronize each button, accept a new level only after it has held for the full debounce window
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stablePrev_q <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q      <= btnRaw;
      sync2_q      <= sync1_q;
      stablePrev_q <= stable_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_q[i] <= sync2_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Simultaneous opposite buttons cancel each other out
  logic pMode, mvLeft, mvRight, edUp, edDown;
  assign pMode   = press[0];
  assign mvLeft  = press[1] & ~press[2];
  assign mvRight = press[2] & ~press[1];
  assign edUp    = press[3] & ~press[4];
  assign edDown  = press[4] & ~press[3];

  logic [1:0]     state_q, state_d;
  logic [2:0]     pos_q, pos_d;
  logic           setMod_q, setMod_d;
  logic           alarmEdit_q, alarmEdit_d;
  logic           inc_q, inc_d;
  logic           dec_q, dec_d;
  logic [5:0]     alarmH_q, alarmH_d;
  logic [5:0]     alarmM_q, alarmM_d;
  logic           alarmEn_q, alarmEn_d;
  logic           ringing_q, ringing_d;
  logic           snooze_q, snooze_d;
  logic [5:0]     snzH_q, snzH_d;
  logic [5:0]     snzM_q, snzM_d;
  logic [RCW-1:0] ringCnt_q, ringCnt_d;
  logic           matchPrev_q;

  logic [6:0] snzSum;
  logic [5:0] snzHNext, snzMNext;
  logic [5:0] tgtH, tgtM;
  logic       match, matchRise;

  // Snooze target is the current time plus the snooze delay, wrapping the hour at midnight
  always_comb begin
    snzSum   = {1'b0, minutes} + 7'(SNOOZE_MINUTES);
    snzHNext = hours;
    snzMNext = snzSum[5:0];
    if (snzSum >= 7'd60) begin
      snzMNext = 6'(snzSum - 7'd60);
      snzHNext = (hours >= 6'd23) ? 6'd0 : hours + 6'd1;
    end
  end

  // Alarm compare against either the programmed alarm or the pending snooze time
  always_comb begin
    tgtH      = snooze_q ? snzH_q : alarmH_q;
    tgtM      = snooze_q ? snzM_q : alarmM_q;
    match     = (state_q == ST_RUN) && alarmEn_q && (hours == tgtH) &&
                (minutes == tgtM) && (seconds == 6'd0);
    matchRise = match & ~matchPrev_q;
  end

  // Mode sequencing, cursor movement, field edits and alarm ring/snooze handling
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    inc_d     = 1'b0;
    dec_d     = 1'b0;
    alarmH_d  = alarmH_q;
    alarmM_d  = alarmM_q;
    alarmEn_d = alarmEn_q;
    ringing_d = ringing_q;
    snooze_d  = snooze_q;
    snzH_d    = snzH_q;
    snzM_d    = snzM_q;
    ringCnt_d = ringCnt_q;

    if (pMode) begin
      // A mode press while ringing only silences the alarm
      ringing_d = 1'b0;
      snooze_d  = 1'b0;
      if (!ringing_q) begin
        case (state_q)
          ST_RUN: begin
            state_d = ST_SET_TIME;
            pos_d   = POS_HOURS;
          end
          ST_SET_TIME: begin
            state_d = ST_SET_ALARM;
            pos_d   = POS_HOURS;
          end
          default: begin
            state_d = ST_RUN;
            pos_d   = POS_NONE;
          end
        endcase
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ringing_q) begin
            if (edUp) begin
              ringing_d = 1'b0;
              snooze_d  = 1'b1;
              snzH_d    = snzHNext;
              snzM_d    = snzMNext;
            end else if (edDown) begin
              ringing_d = 1'b0;
              snooze_d  = 1'b0;
            end else if (one_hz_tick) begin
              if (ringCnt_q <= RING_ONE) begin
                ringing_d = 1'b0;
                ringCnt_d = '0;
              end else begin
                ringCnt_d = ringCnt_q - RING_ONE;
              end
            end
          end else if (edUp) begin
            alarmEn_d = ~alarmEn_q;
            if (alarmEn_q) snooze_d = 1'b0;
          end else if (matchRise) begin
            ringing_d = 1'b1;
            ringCnt_d = RING_LOAD;
            snooze_d  = 1'b0;
          end
        end
        ST_SET_TIME: begin
          inc_d = edUp;
          dec_d = edDown;
          if (mvLeft) begin
            pos_d = (pos_q == POS_HOURS) ? POS_SECONDS : pos_q - 3'd1;
          end else if (mvRight) begin
            pos_d = (pos_q >= POS_SECONDS) ? POS_HOURS : pos_q + 3'd1;
          end
        end
        ST_SET_ALARM: begin
          if (pos_q == POS_HOURS) begin
            if (edUp)   alarmH_d = (alarmH_q >= 6'd23) ? 6'd0 : alarmH_q + 6'd1;
            if (edDown) alarmH_d = (alarmH_q == 6'd0) ? 6'd23 : alarmH_q - 6'd1;
          end else begin
            if (edUp)   alarmM_d = (alarmM_q >= 6'd59) ? 6'd0 : alarmM_q + 6'd1;
            if (edDown) alarmM_d = (alarmM_q == 6'd0) ? 6'd59 : alarmM_q - 6'd1;
          end
          if (mvLeft || mvRight) begin
            pos_d = (pos_q == POS_HOURS) ? POS_MINUTES : POS_HOURS;
          end
        end
        default: begin
          state_d = ST_RUN;
          pos_d   = POS_NONE;
        end
      endcase
    end

    setMod_d    = (state_d == ST_SET_TIME);
    alarmEdit_d = (state_d == ST_SET_ALARM);
  end

  // Controller state and all outputs are registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      pos_q       <= POS_NONE;
      setMod_q    <= 1'b0;
      alarmEdit_q <= 1'b0;
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
      alarmH_q    <= '0;
      alarmM_q    <= '0;
      alarmEn_q   <= 1'b0;
      ringing_q   <= 1'b0;
      snooze_q    <= 1'b0;
      snzH_q      <= '0;
      snzM_q      <= '0;
      ringCnt_q   <= '0;
      matchPrev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      setMod_q    <= setMod_d;
      alarmEdit_q <= alarmEdit_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
      alarmH_q    <= alarmH_d;
      alarmM_q    <= alarmM_d;
      alarmEn_q   <= alarmEn_d;
      ringing_q   <= ringing_d;
      snooze_q    <= snooze_d;
      snzH_q      <= snzH_d;
      snzM_q      <= snzM_d;
      ringCnt_q   <= ringCnt_d;
      matchPrev_q <= match;
    end
  end

  assign set_mod       = setMod_q;
  assign alarm_edit    = alarmEdit_q;
  assign pos           = pos_q;
  assign inc           = inc_q;
  assign dec           = dec_q;
  assign alarm_hours   = alarmH_q;
  assign alarm_minutes = alarmM_q;
  assign alarm_en      = alarmEn_q;
  assign ringing       = ringing_q;

endmodule
